mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined CPU.
- Owns the arbitration FSM, the memory request handshake, fetch-flush discard on branch redirect, and IF starvation protection.
- Drives the per-stage stall signals consumed by the hazard/stall logic.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width; strobe width is DATA_W/8
IF_STARVE_MAX, 4, consecutive data grants made while if_req is pending before IF is forced priority; 0 = data always wins

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request, held until if_valid or if_flush
if_addr  in  ADDR_W  fetch address
if_flush  in  1  branch redirect; discard any in-flight or pending fetch
if_valid  out  1  fetch data valid pulse
if_rdata  out  DATA_W  fetch data
if_stall  out  1  fetch waiting
d_req  in  1  load/store request, held until d_valid
d_we  in  1  1 = store
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_wstrb  in  DATA_W/8  byte enables
d_valid  out  1  load/store complete pulse
d_rdata  out  DATA_W  load data
d_stall  out  1  data access waiting
m_req  out  1  memory request, held until m_done
m_we  out  1  memory write
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_wstrb  out  DATA_W/8  memory byte enables
m_done  in  1  memory completion pulse; m_rdata valid this cycle
m_rdata  in  DATA_W  memory read data

Behaviour:
- All state changes on posedge clk. rst has priority over everything.
- Reset values: state IDLE, m_req/m_we 0, m_addr/m_wdata/m_wstrb 0, starve_cnt 0, discard 0. Outputs if_valid, d_valid, if_stall and d_stall are 0 whenever rst is held.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration (evaluated each cycle):
  - If d_req, and not (if_req && !if_flush && IF_STARVE_MAX != 0 && starve_cnt >= IF_STARVE_MAX): go to BUSY_D.
  - Else if if_req && !if_flush: go to BUSY_I.
  - Else stay in IDLE.
- Entering a BUSY state registers m_req=1 and latches m_we, m_addr, m_wdata and m_wstrb from the granted requester. For a fetch: m_we=0, m_wstrb=0, m_wdata=0.
- Latched values hold for the whole transaction; requester input changes while BUSY are ignored.
- starve_cnt:
  - D grant while if_req && !if_flush: increment, saturating at IF_STARVE_MAX.
  - Any I grant: clear.
  - D grant with no pending fetch: clear.
- BUSY_x: hold m_req until m_done. On the m_done cycle, return to IDLE and clear m_req and m_we.
- Responses are combinational in the m_done cycle:
  - if_valid = m_done & BUSY_I & !discard & !if_flush.
  - d_valid = m_done & BUSY_D.
  - if_rdata = d_rdata = m_rdata.
- Minimum latency: request seen in IDLE at cycle N, m_req high at N+1, m_done at N+1 at the earliest, so valid at N+1 and the next grant at N+2.
- Stalls: if_stall = if_req & !if_valid & !if_flush; d_stall = d_req & !d_valid.
- Flush:
  - if_flush while BUSY_I sets discard. The transaction still completes on the memory side; if_valid is suppressed. discard clears on the m_done that ends it.
  - if_flush in the same cycle as the m_done of a BUSY_I transaction also suppresses if_valid.
  - if_flush has no effect on BUSY_D.
- m_done while IDLE is ignored.
- Simultaneous if_req and d_req in IDLE with starve_cnt < IF_STARVE_MAX: data wins.
- Reset mid-transaction: state returns to IDLE and m_req drops the next cycle. The memory shares rst and aborts. No valid pulse is emitted.
- Stores return d_valid on m_done; d_rdata is don't-care for stores.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100; memory returns m_done one cycle after m_req with m_rdata=0xDEADBEEF. Required: m_addr=0x100 and m_we=0; if_valid=1 with if_rdata=0xDEADBEEF two cycles after the request; if_stall=1 in between.
- Conflict: if_req and d_req (load at 0x200) both asserted in IDLE. Required: m_addr=0x200 first, d_valid first, then m_addr=IF address, then if_valid; if_stall=1 throughout the data transaction.
- Starvation with IF_STARVE_MAX=2: if_req held and d_req held continuously. Required grant sequence D, D, I, D, D, I.
- Flush: fetch at 0x300 in BUSY_I with 3-cycle memory latency; pulse if_flush in the second cycle. Required: transaction completes, no if_valid, discard clears; a new if_req to 0x400 is issued afterwards.
- Store: d_we=1, d_addr=0x40, d_wdata=0x12345678, d_wstrb=4'b0011. Required: m_we=1, m_wstrb=0011 and m_wdata matching d_wdata; d_valid on m_done; m_we=0 the next cycle.
- Reset mid-op: assert rst while in BUSY_D. Required: next cycle m_req=0, state IDLE, starve_cnt=0; a later stray m_done produces no valid pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch and load/store.
//   Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int IF_STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_valid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_stall,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_done,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int CW = (IF_STARVE_MAX < 1) ? 1 : $clog2(IF_STARVE_MAX + 1);
  localparam logic [CW-1:0] c_STARVE_MAX = CW'(IF_STARVE_MAX);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_BUSY_I = 2'd1;
  localparam logic [1:0] c_BUSY_D = 2'd2;

  logic [1:0]          r_state;
  logic                r_m_req;
  logic                r_m_we;
  logic [ADDR_W-1:0]   r_m_addr;
  logic [DATA_W-1:0]   r_m_wdata;
  logic [DATA_W/8-1:0] r_m_wstrb;
  logic [CW-1:0]       r_starve_cnt;
  logic                r_discard;

  logic w_if_pend;
  logic w_force_i;
  logic w_grant_d;
  logic w_grant_i;

  assign w_if_pend = if_req & ~if_flush;
  // Once the fetch has lost IF_STARVE_MAX times in a row it takes the port.
  assign w_force_i = w_if_pend && (IF_STARVE_MAX != 0) && (r_starve_cnt >= c_STARVE_MAX);
  assign w_grant_d = (r_state == c_IDLE) && d_req && !w_force_i;
  assign w_grant_i = (r_state == c_IDLE) && !w_grant_d && w_if_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_m_req      <= 1'b0;
      r_m_we       <= 1'b0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_m_wstrb    <= '0;
      r_starve_cnt <= '0;
      r_discard    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_grant_d) begin
            r_state   <= c_BUSY_D;
            r_m_req   <= 1'b1;
            r_m_we    <= d_we;
            r_m_addr  <= d_addr;
            r_m_wdata <= d_wdata;
            r_m_wstrb <= d_wstrb;
            if (!w_if_pend)
              r_starve_cnt <= '0;
            else if (r_starve_cnt != c_STARVE_MAX)
              r_starve_cnt <= r_starve_cnt + CW'(1);
          end else if (w_grant_i) begin
            r_state      <= c_BUSY_I;
            r_m_req      <= 1'b1;
            r_m_we       <= 1'b0;
            r_m_addr     <= if_addr;
            r_m_wdata    <= '0;
            r_m_wstrb    <= '0;
            r_starve_cnt <= '0;
          end
        end
        c_BUSY_I, c_BUSY_D: begin
          if (m_done) begin
            r_state   <= c_IDLE;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_discard <= 1'b0;
          end else if ((r_state == c_BUSY_I) && if_flush) begin
            r_discard <= 1'b1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign m_req   = r_m_req;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign m_wstrb = r_m_wstrb;

  assign if_valid = ~rst & m_done & (r_state == c_BUSY_I) & ~r_discard & ~if_flush;
  assign d_valid  = ~rst & m_done & (r_state == c_BUSY_D);
  assign if_rdata = m_rdata;
  assign d_rdata  = m_rdata;
  assign if_stall = ~rst & if_req & ~if_valid & ~if_flush;
  assign d_stall  = ~rst & d_req & ~d_valid;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter
//   Directed vector table, starvation sequence and randomized model compare.
//   Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arbiter;
  localparam int SMAX = 2;

  logic        clk = 1'b0;
  logic        rst, if_req, if_flush, d_req, d_we, m_done;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_wstrb;
  logic        if_valid, if_stall, d_valid, d_stall, m_req, m_we;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_wstrb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .IF_STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_done(m_done), .m_rdata(m_rdata)
  );

  typedef struct {
    logic        r, ir;  logic [31:0] ia;  logic fl, dr, dw;
    logic [31:0] da, dd; logic [3:0] ds;   logic md; logic [31:0] mr;
    logic        emr, emw; logic [31:0] ema, emd; logic [3:0] ems;
    logic        eiv, edv, eis, eds;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic r, ir, input logic [31:0] ia, input logic fl, dr, dw,
                             input logic [31:0] da, dd, input logic [3:0] ds, input logic md,
                             input logic [31:0] mr, input logic emr, emw, input logic [31:0] ema, emd,
                             input logic [3:0] ems, input logic eiv, edv, eis, eds);
    vec_t x;
    x.r = r; x.ir = ir; x.ia = ia; x.fl = fl; x.dr = dr; x.dw = dw; x.da = da; x.dd = dd;
    x.ds = ds; x.md = md; x.mr = mr; x.emr = emr; x.emw = emw; x.ema = ema; x.emd = emd;
    x.ems = ems; x.eiv = eiv; x.edv = edv; x.eis = eis; x.eds = eds;
    return x;
  endfunction

  function automatic logic [73:0] dut_bundle();
    return {m_req, m_we, m_addr, m_wdata, m_wstrb, if_valid, d_valid, if_stall, d_stall};
  endfunction

  task automatic check(input string name, input logic [73:0] got, input logic [73:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, ir, input logic [31:0] ia, input logic fl, dr, dw,
                       input logic [31:0] da, dd, input logic [3:0] ds, input logic md,
                       input logic [31:0] mr);
    rst = r; if_req = ir; if_addr = ia; if_flush = fl; d_req = dr; d_we = dw;
    d_addr = da; d_wdata = dd; d_wstrb = ds; m_done = md; m_rdata = mr;
  endtask

  // Reference model state: who owns the memory and what was latched for it.
  int          mo_owner;  // 0 idle, 1 fetch, 2 data
  logic        mo_req, mo_we, mo_disc;
  logic [31:0] mo_addr, mo_wdata;
  logic [3:0]  mo_wstrb;
  int          mo_starve;

  initial begin
    logic [5:0]  g;
    int          glen;
    logic        prev;
    logic        fetch_wanted, if_forced, eiv, edv, eis, eds;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    //          r ir ia      fl dr dw da     dd            ds  md mr            emr emw ema    emd           ems iv dv is ds
    vecs.push_back(v(1,1,32'h0,  0,1,0,32'h0,  32'h0,        4'h0,1,32'h0,        0,0,32'h0,  32'h0,        4'h0,0,0,0,0));
    // single fetch
    vecs.push_back(v(0,1,32'h100,0,0,0,32'h0,  32'h0,        4'h0,0,32'h0,        0,0,32'h0,  32'h0,        4'h0,0,0,1,0));
    vecs.push_back(v(0,1,32'h100,0,0,0,32'h0,  32'h0,        4'h0,0,32'h0,        1,0,32'h100,32'h0,        4'h0,0,0,1,0));
    vecs.push_back(v(0,1,32'h100,0,0,0,32'h0,  32'h0,        4'h0,1,32'hDEADBEEF, 1,0,32'h100,32'h0,        4'h0,1,0,0,0));
    vecs.push_back(v(0,0,32'h0,  0,0,0,32'h0,  32'h0,        4'h0,0,32'h0,        0,0,32'h100,32'h0,        4'h0,0,0,0,0));
    // conflict: data wins, then fetch
    vecs.push_back(v(0,1,32'h104,0,1,0,32'h200,32'hAAAA5555, 4'h0,0,32'h0,        0,0,32'h100,32'h0,        4'h0,0,0,1,1));
    vecs.push_back(v(0,1,32'h104,0,1,0,32'h200,32'hAAAA5555, 4'h0,0,32'h0,        1,0,32'h200,32'hAAAA5555, 4'h0,0,0,1,1));
    vecs.push_back(v(0,1,32'h104,0,1,0,32'h200,32'hAAAA5555, 4'h0,1,32'h11112222, 1,0,32'h200,32'hAAAA5555, 4'h0,0,1,1,0));
    vecs.push_back(v(0,1,32'h104,0,0,0,32'h0,  32'h0,        4'h0,0,32'h0,        0,0,32'h200,32'hAAAA5555, 4'h0,0,0,1,0));
    vecs.push_back(v(0,1,32'h104,0,0,0,32'h0,  32'h0,        4'h0,1,32'h33334444, 1,0,32'h104,32'h0,        4'h0,1,0,0,0));
    vecs.push_back(v(0,0,32'h0,  0,0,0,32'h0,  32'h0,        4'h0,0,32'h0,        0,0,32'h104,32'h0,        4'h0,0,0,0,0));
    // store
    vecs.push_back(v(0,0,32'h0,  0,1,1,32'h40, 32'h12345678, 4'h3,0,32'h0,        0,0,32'h104,32'h0,        4'h0,0,0,0,1));
    vecs.push_back(v(0,0,32'h0,  0,1,1,32'h40, 32'h12345678, 4'h3,0,32'h0,        1,1,32'h40, 32'h12345678, 4'h3,0,0,0,1));
    vecs.push_back(v(0,0,32'h0,  0,1,1,32'h40, 32'h12345678, 4'h3,1,32'h0,        1,1,32'h40, 32'h12345678, 4'h3,0,1,0,0));
    vecs.push_back(v(0,0,32'h0,  0,0,0,32'h0,  32'h0,        4'h0,0,32'h0,        0,0,32'h40, 32'h12345678, 4'h3,0,0,0,0));
    // flush mid-fetch with 3-cycle memory latency, then a fresh fetch
    vecs.push_back(v(0,1,32'h300,0,0,0,32'h0,  32'h0,        4'h0,0,32'h0,        0,0,32'h40, 32'h12345678, 4'h3,0,0,1,0));
    vecs.push_back(v(0,1,32'h300,0,0,0,32'h0,  32'h0,        4'h0,0,32'h0,        1,0,32'h300,32'h0,        4'h0,0,0,1,0));
    vecs.push_back(v(0,1,32'h300,1,0,0,32'h0,  32'h0,        4'h0,0,32'h0,        1,0,32'h300,32'h0,        4'h0,0,0,0,0));
    vecs.push_back(v(0,0,32'h0,  0,0,0,32'h0,  32'h0,        4'h0,1,32'h00000BAD, 1,0,32'h300,32'h0,        4'h0,0,0,0,0));
    vecs.push_back(v(0,1,32'h400,0,0,0,32'h0,  32'h0,        4'h0,0,32'h0,        0,0,32'h300,32'h0,        4'h0,0,0,1,0));
    vecs.push_back(v(0,1,32'h400,0,0,0,32'h0,  32'h0,        4'h0,1,32'hCAFE0400, 1,0,32'h400,32'h0,        4'h0,1,0,0,0));
    // flush coincident with m_done, then a stray m_done in IDLE
    vecs.push_back(v(0,1,32'h500,0,0,0,32'h0,  32'h0,        4'h0,0,32'h0,        0,0,32'h400,32'h0,        4'h0,0,0,1,0));
    vecs.push_back(v(0,1,32'h500,1,0,0,32'h0,  32'h0,        4'h0,1,32'h55555555, 1,0,32'h500,32'h0,        4'h0,0,0,0,0));
    vecs.push_back(v(0,0,32'h0,  0,0,0,32'h0,  32'h0,        4'h0,1,32'h66666666, 0,0,32'h500,32'h0,        4'h0,0,0,0,0));
    // reset while BUSY_D (fetch pending so the starve count is nonzero)
    vecs.push_back(v(0,1,32'h580,0,1,0,32'h600,32'h77777777, 4'hF,0,32'h0,        0,0,32'h500,32'h0,        4'h0,0,0,1,1));
    vecs.push_back(v(1,1,32'h580,0,1,0,32'h600,32'h77777777, 4'hF,1,32'h0,        1,0,32'h600,32'h77777777, 4'hF,0,0,0,0));
    vecs.push_back(v(0,0,32'h0,  0,0,0,32'h0,  32'h0,        4'h0,1,32'h88888888, 0,0,32'h0,  32'h0,        4'h0,0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      drive(vecs[i].r, vecs[i].ir, vecs[i].ia, vecs[i].fl, vecs[i].dr, vecs[i].dw,
            vecs[i].da, vecs[i].dd, vecs[i].ds, vecs[i].md, vecs[i].mr);
      #3;
      check($sformatf("vec%0d", i), dut_bundle(),
            {vecs[i].emr, vecs[i].emw, vecs[i].ema, vecs[i].emd, vecs[i].ems,
             vecs[i].eiv, vecs[i].edv, vecs[i].eis, vecs[i].eds});
      if (vecs[i].eiv) check($sformatf("vec%0d_if_rdata", i), {42'd0, if_rdata}, {42'd0, vecs[i].mr});
      if (vecs[i].edv) check($sformatf("vec%0d_d_rdata", i), {42'd0, d_rdata}, {42'd0, vecs[i].mr});
    end

    // Both requesters held, memory completes immediately: grants must be D,D,I,D,D,I.
    g = '0; glen = 0; prev = 1'b0;
    for (int c = 0; c < 40 && glen < 6; c++) begin
      @(posedge clk); #1;
      drive(0, 1, 32'h700, 0, 1, 0, 32'h800, 32'h0, 4'h0, m_req, 32'(c));
      #3;
      if (m_req && !prev) begin
        g = {g[4:0], (m_addr == 32'h800)};
        glen++;
      end
      prev = m_req;
    end
    check("starve_grant_seq", {68'd0, g}, {68'd0, 6'b110110});
    check("starve_grant_count", 74'(glen), 74'd6);

    // Randomized traffic against the reference model.
    mo_owner = 0; mo_req = 0; mo_we = 0; mo_disc = 0;
    mo_addr = '0; mo_wdata = '0; mo_wstrb = '0; mo_starve = 0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(posedge clk); #1;
      drive((cyc < 2) || ($urandom_range(0, 99) == 0),
            $urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 9) == 0,
            $urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1, $urandom, $urandom,
            4'($urandom), $urandom_range(0, 2) == 0, $urandom);
      #3;
      eiv = !rst && m_done && mo_owner == 1 && !mo_disc && !if_flush;
      edv = !rst && m_done && mo_owner == 2;
      eis = !rst && if_req && !eiv && !if_flush;
      eds = !rst && d_req && !edv;
      if (cyc > 0) begin
        check($sformatf("rand%0d", cyc), dut_bundle(),
              {mo_req, mo_we, mo_addr, mo_wdata, mo_wstrb, eiv, edv, eis, eds});
        if (eiv) check($sformatf("rand%0d_if_rdata", cyc), {42'd0, if_rdata}, {42'd0, m_rdata});
        if (edv) check($sformatf("rand%0d_d_rdata", cyc), {42'd0, d_rdata}, {42'd0, m_rdata});
      end
      if (rst) begin
        mo_owner = 0; mo_req = 0; mo_we = 0; mo_disc = 0;
        mo_addr = '0; mo_wdata = '0; mo_wstrb = '0; mo_starve = 0;
      end else if (mo_owner == 0) begin
        fetch_wanted = if_req && !if_flush;
        if_forced = fetch_wanted && SMAX > 0 && mo_starve >= SMAX;
        if (d_req && !if_forced) begin
          mo_owner = 2; mo_req = 1; mo_we = d_we;
          mo_addr = d_addr; mo_wdata = d_wdata; mo_wstrb = d_wstrb;
          mo_starve = fetch_wanted ? ((mo_starve + 1 > SMAX) ? SMAX : mo_starve + 1) : 0;
        end else if (fetch_wanted) begin
          mo_owner = 1; mo_req = 1; mo_we = 0;
          mo_addr = if_addr; mo_wdata = '0; mo_wstrb = '0;
          mo_starve = 0;
        end
      end else if (m_done) begin
        mo_owner = 0; mo_req = 0; mo_we = 0; mo_disc = 0;
      end else if (mo_owner == 1 && if_flush) begin
        mo_disc = 1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
